traffic_scheduler: RTL and testbench
====================================

# traffic_scheduler

Sequences all car lanes of the road section: owns a shared base-tick prescaler, schedules a per-lane move at a lane- and level-dependent rate, and maintains every car's wrapped x position. Sits between the game-control logic (start/pause/collision/level) and the car sprite renderers, which consume `o_Lane_X` directly.

## Interface
- `NUM_LANES`, 4: number of car lanes (fixed table size, see Structure).
- `GRID_W`, 20: horizontal cell count; positions span 0..GRID_W-1 (GRID_W ≤ 32).
- `TICK_DIV`, 12_500_000: clock cycles per base tick (0.5 s at 25 MHz).
- `i_Clk`  in  1  25 MHz system clock; the only clock.
- `i_Rst_L`  in  1  reset, asynchronous, active-low.
- `i_Start`  in  1  one-cycle pulse: (re)start traffic.
- `i_Pause`  in  1  level: freeze traffic while high.
- `i_Collision`  in  1  one-cycle pulse: frog hit, stop traffic.
- `i_Level`  in  2  difficulty; sampled only in LOAD.
- `o_Lane_X`  out  5*NUM_LANES  packed positions, lane k at [5k+4:5k].
- `o_Move`  out  NUM_LANES  one-cycle strobe, bit k = lane k moved this cycle.
- `o_Base_Tick`  out  1  one-cycle strobe per base tick.
- `o_Running`  out  1  high while state is RUN.

## Operation
- States: IDLE (reset), LOAD, RUN, PAUSE, HALT.
- Input priority each cycle: i_Start > i_Collision > i_Pause.
- IDLE: i_Start → LOAD. LOAD → RUN unconditionally (one cycle).
- RUN: i_Start → LOAD; i_Collision → HALT; i_Pause → PAUSE.
- PAUSE: i_Start → LOAD; i_Pause low → RUN; i_Collision ignored.
- HALT: i_Start → LOAD; all else ignored.
- LOAD: prescaler and lane counters cleared; level latched; lane k position ← INIT_X[k] = 5k mod GRID_W (0,5,10,15).
- Lane period (in base ticks) = max(1, BASE_PERIOD[k] − level), BASE_PERIOD = {4,6,3,5}; 3-bit lane counters.
- Direction: even lanes +1, wrap GRID_W-1 → 0; odd lanes −1, wrap 0 → GRID_W-1.
- Prescaler counts only in RUN, holds in PAUSE/HALT/IDLE; wraps TICK_DIV-1 → 0 and raises base tick.
- On a base tick with state still RUN: each lane counter increments; lane reaching period-1 clears to 0, moves one cell, strobes o_Move[k].
- Reset values: state IDLE, o_Lane_X all 0, o_Move 0, o_Base_Tick 0, o_Running 0, all counters 0.

## Timing
- All outputs registered.
- Cycle S: i_Start sampled; S+1 LOAD; S+2 RUN, o_Running=1, o_Lane_X = initial positions.
- Cycle T: prescaler = TICK_DIV-1; T+1 o_Base_Tick=1, prescaler=0; T+2 o_Move[k]=1 and o_Lane_X shows the new position (2-cycle latency).
- First base tick after LOAD arrives TICK_DIV cycles after RUN entry.
- i_Collision or i_Pause in the cycle o_Base_Tick is high: state leaves RUN, pending lane update is dropped, no o_Move, lane counters unchanged.
- PAUSE → RUN resumes prescaler from held value; no tick lost or duplicated.
- i_Start during RUN: restart; any pending update dropped.
- i_Rst_L low at any time: all state and outputs to reset values immediately, without a clock edge; release synchronized by the top level.

## Structure
- Shared package `traffic_pkg`: state encoding, BASE_PERIOD and INIT_X tables, POS_W=5, LANE_CNT_W=3.
- One sub-module `lane_mover` (period counter, direction, wrapping position register, move strobe), instantiated NUM_LANES times; the scheduler holds FSM, prescaler, and level latch.

## Test plan
- TICK_DIV=4, level 0, reset then i_Start: o_Running high at S+2, positions 0,5,10,15; lane 2 (period 3) reaches 11 after 3 base ticks with o_Move[2] single-cycle, o_Move[0] not yet strobed.
- Wrap: run until lane 0 = 19 and lane 1 = 0; next moves give lane 0 = 0, lane 1 = 19.
- Level 3: periods {1,3,1,2}; lanes 0 and 2 strobe on every base tick, lane 1 every third, lane 3 every second.
- Pause held 10 cycles mid-prescale (prescaler=2): no o_Base_Tick during pause; tick occurs 2 cycles after release.
- i_Collision coincident with o_Base_Tick: HALT, no o_Move, positions frozen, o_Running 0; further i_Pause ignored; i_Start restores initial positions.
- Async reset asserted mid-RUN between clock edges: all outputs 0 before next edge; after release, state IDLE until i_Start.

Source files
------------

// File: rtl/traffic_scheduler_pkg.sv
// Shared types and lane tables for the road-section traffic scheduler.
// Lane tables are sized for four lanes; NUM_LANES must not exceed TBL_LANES.
package traffic_pkg;

  localparam int POS_W      = 5;
  localparam int LANE_CNT_W = 3;
  localparam int TBL_LANES  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_PAUSE,
    ST_HALT
  } state_t;

  // Lane k occupies element [k]; base periods are in base ticks.
  localparam logic [TBL_LANES-1:0][LANE_CNT_W-1:0] BASE_PERIOD = {3'd5, 3'd3, 3'd6, 3'd4};

  // Higher levels shorten the period, but a lane never moves faster than once per tick.
  function automatic logic [LANE_CNT_W-1:0] lane_period(input logic [LANE_CNT_W-1:0] base,
                                                        input logic [1:0] lvl);
    logic [LANE_CNT_W-1:0] w_Lvl;
    w_Lvl = LANE_CNT_W'(lvl);
    return (base > w_Lvl) ? base - w_Lvl : LANE_CNT_W'(1);
  endfunction

  function automatic logic [POS_W-1:0] init_x(input int k, input int grid_w);
    return POS_W'((5 * k) % grid_w);
  endfunction

endpackage

// File: rtl/traffic_scheduler_if.sv
// Control/observation bundle between game control (master) and the scheduler (slave).
interface traffic_scheduler_if
  import traffic_pkg::*;
#(
  parameter int NUM_LANES = 4
);
  logic                                i_Start;
  logic                                i_Pause;
  logic                                i_Collision;
  logic [1:0]                          i_Level;
  logic [NUM_LANES-1:0][POS_W-1:0]     o_Lane_X;
  logic [NUM_LANES-1:0]                o_Move;
  logic                                o_Base_Tick;
  logic                                o_Running;

  modport master (
    output i_Start, i_Pause, i_Collision, i_Level,
    input  o_Lane_X, o_Move, o_Base_Tick, o_Running
  );

  modport slave (
    input  i_Start, i_Pause, i_Collision, i_Level,
    output o_Lane_X, o_Move, o_Base_Tick, o_Running
  );
endinterface

// File: rtl/traffic_scheduler_lane_mover.sv
// One car lane: period counter, wrapping x position and a one-cycle move strobe.
module lane_mover
  import traffic_pkg::*;
#(
  parameter int GRID_W   = 20,
  parameter bit DIR_DOWN = 1'b0
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_Load,
  input  logic                  i_Adv,
  input  logic [LANE_CNT_W-1:0] i_Period,
  input  logic [POS_W-1:0]      i_Init_X,
  output logic [POS_W-1:0]      o_X,
  output logic                  o_Move
);

  logic [LANE_CNT_W-1:0] r_Cnt;
  logic [POS_W-1:0]      r_X;
  logic                  r_Move;
  logic [POS_W-1:0]      w_X_Next;

  always_comb begin
    w_X_Next = r_X;
    if (DIR_DOWN)
      w_X_Next = (r_X == '0) ? POS_W'(GRID_W - 1) : r_X - POS_W'(1);
    else
      w_X_Next = (r_X == POS_W'(GRID_W - 1)) ? '0 : r_X + POS_W'(1);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Cnt  <= '0;
      r_X    <= '0;
      r_Move <= 1'b0;
    end else begin
      r_Move <= 1'b0;
      if (i_Load) begin
        r_Cnt <= '0;
        r_X   <= i_Init_X;
      end else if (i_Adv) begin
        // The counter counts completed ticks of the current period, so the
        // move lands on the period-th tick after the last one.
        if (r_Cnt == i_Period - LANE_CNT_W'(1)) begin
          r_Cnt  <= '0;
          r_X    <= w_X_Next;
          r_Move <= 1'b1;
        end else begin
          r_Cnt <= r_Cnt + LANE_CNT_W'(1);
        end
      end
    end
  end

  assign o_X    = r_X;
  assign o_Move = r_Move;

endmodule

// File: rtl/traffic_scheduler.sv
// Traffic sequencer: run-state FSM, shared base-tick prescaler, level latch and lane array.
module traffic_scheduler
  import traffic_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int GRID_W    = 20,
  parameter int TICK_DIV  = 12_500_000
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  traffic_scheduler_if.slave  bus
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [1:0]                      r_Rst_Sync;
  logic                            w_Rst_L;
  state_t                          r_State;
  state_t                          w_Next;
  logic [PRE_W-1:0]                r_Pre;
  logic                            r_Base_Tick;
  logic                            r_Running;
  logic [1:0]                      r_Level;
  logic                            w_Load;
  logic                            w_Adv;
  logic [NUM_LANES-1:0][POS_W-1:0] w_Lane_X;
  logic [NUM_LANES-1:0]            w_Move;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_Rst_Sync <= '0;
    else          r_Rst_Sync <= {r_Rst_Sync[0], 1'b1};
  end
  assign w_Rst_L = r_Rst_Sync[1];

  always_ff @(posedge i_Clk or negedge w_Rst_L) begin
    if (!w_Rst_L) r_State <= ST_IDLE;
    else          r_State <= w_Next;
  end

  always_comb begin
    w_Next = r_State;
    unique case (r_State)
      ST_IDLE:  if (bus.i_Start) w_Next = ST_LOAD;
      ST_LOAD:  w_Next = ST_RUN;
      ST_RUN: begin
        if      (bus.i_Start)     w_Next = ST_LOAD;
        else if (bus.i_Collision) w_Next = ST_HALT;
        else if (bus.i_Pause)     w_Next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if      (bus.i_Start)  w_Next = ST_LOAD;
        else if (!bus.i_Pause) w_Next = ST_RUN;
      end
      ST_HALT:  if (bus.i_Start) w_Next = ST_LOAD;
      default:  w_Next = ST_IDLE;
    endcase
  end

  assign w_Load = (r_State == ST_LOAD);
  // A tick is honoured only if traffic is still running after this edge.
  assign w_Adv  = r_Base_Tick && (r_State == ST_RUN) && (w_Next == ST_RUN);

  always_ff @(posedge i_Clk or negedge w_Rst_L) begin
    if (!w_Rst_L) begin
      r_Pre       <= '0;
      r_Base_Tick <= 1'b0;
      r_Running   <= 1'b0;
      r_Level     <= '0;
    end else begin
      r_Running   <= (w_Next == ST_RUN);
      r_Base_Tick <= 1'b0;
      if (w_Load) begin
        r_Pre   <= '0;
        r_Level <= bus.i_Level;
      end else if (r_State == ST_RUN) begin
        if (r_Pre == PRE_W'(TICK_DIV - 1)) begin
          r_Pre       <= '0;
          r_Base_Tick <= 1'b1;
        end else begin
          r_Pre <= r_Pre + PRE_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [LANE_CNT_W-1:0] w_Period;
    assign w_Period = lane_period(BASE_PERIOD[k], r_Level);

    lane_mover #(
      .GRID_W   (GRID_W),
      .DIR_DOWN (k % 2 == 1)
    ) u_lane (
      .i_Clk    (i_Clk),
      .i_Rst_L  (w_Rst_L),
      .i_Load   (w_Load),
      .i_Adv    (w_Adv),
      .i_Period (w_Period),
      .i_Init_X (init_x(k, GRID_W)),
      .o_X      (w_Lane_X[k]),
      .o_Move   (w_Move[k])
    );
  end

  assign bus.o_Lane_X    = w_Lane_X;
  assign bus.o_Move      = w_Move;
  assign bus.o_Base_Tick = r_Base_Tick;
  assign bus.o_Running   = r_Running;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Directed bench for traffic_scheduler with a per-cycle behavioural reference model.
module tb_traffic_scheduler;

  localparam int NL = 4;
  localparam int GW = 20;
  localparam int TD = 4;
  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_PAUSE = 3, S_HALT = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  traffic_scheduler_if #(.NUM_LANES(NL)) bus ();

  traffic_scheduler #(.NUM_LANES(NL), .GRID_W(GW), .TICK_DIV(TD)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-lane count of honoured ticks since LOAD, a move on
  // every multiple of the lane period, positions kept with modulo arithmetic.
  int m_st, m_pre, m_lvl;
  bit m_tick, m_run;
  int m_pos[NL];
  int m_nt[NL];
  bit m_move[NL];

  function automatic int per_of(input int k, input int lvl);
    int base[4] = '{4, 6, 3, 5};
    int p;
    p = base[k] - lvl;
    return (p < 1) ? 1 : p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= S_IDLE; m_pre <= 0; m_tick <= 0; m_run <= 0; m_lvl <= 0;
      for (int k = 0; k < NL; k++) begin
        m_pos[k] <= 0; m_nt[k] <= 0; m_move[k] <= 0;
      end
    end else begin : mstep
      int nxt;
      bit adv;
      nxt = m_st;
      if (m_st == S_LOAD)                          nxt = S_RUN;
      else if (bus.i_Start)                        nxt = S_LOAD;
      else if (m_st == S_RUN && bus.i_Collision)   nxt = S_HALT;
      else if (m_st == S_RUN && bus.i_Pause)       nxt = S_PAUSE;
      else if (m_st == S_PAUSE && !bus.i_Pause)    nxt = S_RUN;
      adv = m_tick && (m_st == S_RUN) && (nxt == S_RUN);
      for (int k = 0; k < NL; k++) begin
        m_move[k] <= 0;
        if (adv) begin
          m_nt[k] <= m_nt[k] + 1;
          if ((m_nt[k] + 1) % per_of(k, m_lvl) == 0) begin
            m_move[k] <= 1;
            m_pos[k]  <= (m_pos[k] + ((k % 2) ? GW - 1 : 1)) % GW;
          end
        end
        if (m_st == S_LOAD) begin
          m_pos[k] <= (5 * k) % GW;
          m_nt[k]  <= 0;
        end
      end
      m_tick <= (m_st == S_RUN) && (m_pre == TD - 1);
      if (m_st == S_RUN)       m_pre <= (m_pre + 1) % TD;
      else if (m_st == S_LOAD) m_pre <= 0;
      if (m_st == S_LOAD) m_lvl <= int'(bus.i_Level);
      m_run <= (nxt == S_RUN);
      m_st  <= nxt;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin : cmp
      logic [25:0] exp_v;
      exp_v[25] = m_run;
      exp_v[24] = m_tick;
      for (int k = 0; k < NL; k++) begin
        exp_v[20+k]  = m_move[k];
        exp_v[5*k+:5] = m_pos[k][4:0];
      end
      chk("model", {6'b0, bus.o_Running, bus.o_Base_Tick, bus.o_Move, bus.o_Lane_X}, {6'b0, exp_v});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the caller at the negedge of the first RUN cycle.
  task automatic start_run(input logic [1:0] lvl);
    bus.i_Start = 1'b1;
    bus.i_Level = lvl;
    cyc(1);
    bus.i_Start = 1'b0;
    chk("load_not_running", {31'b0, bus.o_Running}, 32'd0);
    cyc(1);
    bus.i_Level = 2'd0;
    chk("run_entry", {31'b0, bus.o_Running}, 32'd1);
    chk("init_pos", {12'b0, bus.o_Lane_X}, {12'b0, 5'd15, 5'd10, 5'd5, 5'd0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    bus.i_Start = 1'b0; bus.i_Pause = 1'b0; bus.i_Collision = 1'b0; bus.i_Level = 2'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    cyc(2);
    chk("reset_outs", {6'b0, bus.o_Running, bus.o_Base_Tick, bus.o_Move, bus.o_Lane_X}, 32'd0);
    rst_n = 1'b1;
    cyc(4);
    chk("idle_after_rst", {31'b0, bus.o_Running}, 32'd0);

    // Level 0: first tick TICK_DIV cycles after RUN entry, lane 2 moves on tick 3.
    start_run(2'd0);
    cyc(3);  chk("no_tick_early", {31'b0, bus.o_Base_Tick}, 32'd0);
    cyc(1);  chk("first_tick", {31'b0, bus.o_Base_Tick}, 32'd1);
    cyc(8);  chk("tick3", {31'b0, bus.o_Base_Tick}, 32'd1);
             chk("tick3_no_move", {28'b0, bus.o_Move}, 32'd0);
    cyc(1);  chk("lane2_move", {28'b0, bus.o_Move}, 32'b0100);
             chk("lane2_pos", {27'b0, bus.o_Lane_X[2]}, 32'd11);
             chk("lane0_pos", {27'b0, bus.o_Lane_X[0]}, 32'd0);
    cyc(1);  chk("move_one_cycle", {28'b0, bus.o_Move}, 32'd0);
    cyc(30);

    // Level 3 restart from RUN: periods {1,3,1,2} and wrap in both directions.
    start_run(2'd3);
    cyc(5);  chk("l3_tick1", {28'b0, bus.o_Move}, 32'b0101);
    cyc(4);  chk("l3_tick2", {28'b0, bus.o_Move}, 32'b1101);
    cyc(4);  chk("l3_tick3", {28'b0, bus.o_Move}, 32'b0111);
    cyc(60); chk("lane1_wrap", {27'b0, bus.o_Lane_X[1]}, 32'd19);
             chk("lane0_18", {27'b0, bus.o_Lane_X[0]}, 32'd18);
    cyc(4);  chk("lane0_19", {27'b0, bus.o_Lane_X[0]}, 32'd19);
    cyc(4);  chk("lane0_wrap", {27'b0, bus.o_Lane_X[0]}, 32'd0);
             chk("lane1_hold", {27'b0, bus.o_Lane_X[1]}, 32'd19);

    // Pause with prescaler at 2, held 10 cycles.
    start_run(2'd0);
    cyc(2);  bus.i_Pause = 1'b1;
    cyc(3);  chk("paused", {31'b0, bus.o_Running}, 32'd0);
    cyc(7);  bus.i_Pause = 1'b0;
    cyc(1);  chk("resume_no_tick", {31'b0, bus.o_Base_Tick}, 32'd0);
             chk("resumed", {31'b0, bus.o_Running}, 32'd1);
    cyc(1);  chk("resume_tick", {31'b0, bus.o_Base_Tick}, 32'd1);

    // Collision on the tick that would move lane 2.
    cyc(8);  chk("coll_tick", {31'b0, bus.o_Base_Tick}, 32'd1);
             bus.i_Collision = 1'b1;
    cyc(1);  bus.i_Collision = 1'b0;
             chk("halt_no_move", {28'b0, bus.o_Move}, 32'd0);
             chk("halt_not_running", {31'b0, bus.o_Running}, 32'd0);
             chk("halt_lane2", {27'b0, bus.o_Lane_X[2]}, 32'd10);
    bus.i_Pause = 1'b1;
    cyc(4);  chk("halt_pause_ignored", {31'b0, bus.o_Running}, 32'd0);
    bus.i_Pause = 1'b0;
    cyc(2);

    // Pause coincident with lane 2's tick: update dropped, counter kept.
    start_run(2'd0);
    cyc(12); bus.i_Pause = 1'b1;
    cyc(1);  bus.i_Pause = 1'b0;
             chk("pause_drop", {28'b0, bus.o_Move}, 32'd0);
    cyc(5);  chk("kept_cnt_move", {28'b0, bus.o_Move}, 32'b0100);
             chk("kept_cnt_pos", {27'b0, bus.o_Lane_X[2]}, 32'd11);

    // Asynchronous reset between edges.
    cyc(3);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {6'b0, bus.o_Running, bus.o_Base_Tick, bus.o_Move, bus.o_Lane_X}, 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);  chk("idle_after_async", {6'b0, bus.o_Running, bus.o_Base_Tick, bus.o_Move, bus.o_Lane_X}, 32'd0);
    start_run(2'd1);
    cyc(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
